data_fifo: RTL and testbench

Single-clock, synchronous first-in/first-out buffer for 24-bit sample words. It decouples a producer that writes in bursts from a consumer that reads in bursts, both in the same 12 MHz clock domain. It provides occupancy flags (Empty, Full, AlmostEmpty, AlmostFull) and a read-pointer rewind so a stored block can be replayed.

---
 rtl/data_fifo.sv | 67 ++++++
 tb/tb_data_fifo.sv | 138 +++++++++++++
 2 files changed

// File: rtl/data_fifo.sv
// data_fifo: single-clock 24-bit FIFO with registered flags and read-pointer rewind.
// FIFO_ALMOST_FLAGS_EN enables almost_empty/almost_full; otherwise both are tied low.
module data_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 9,
  parameter int AE_LEVEL = 4,
  parameter int AF_LEVEL = 508
) (
  input  logic                  clk_12mhz,
  input  logic                  reset,
  input  logic                  rp_reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, occ_nxt;
  logic wr_acc, rd_acc;
  always_comb begin
    wr_acc = wr_en && !full;
    rd_acc = rd_en && !empty && !rp_reset;
    wr_nxt = wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_acc};
    rd_nxt = rp_reset ? '0 : rd_ptr + {{ADDR_WIDTH{1'b0}}, rd_acc};
    occ_nxt = wr_nxt - rd_nxt;
  end
  always_ff @(posedge clk_12mhz)
    if (wr_acc && !reset) mem[wr_ptr[ADDR_WIDTH-1:0]] <= data;
  always_ff @(posedge clk_12mhz) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q <= '0;
      empty <= 1'b1;
      full <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      if (rd_acc) q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      empty <= occ_nxt == '0;
      full <= occ_nxt == DEPTH;
    end
  end
`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [ADDR_WIDTH:0] AE = AE_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF = AF_LEVEL[ADDR_WIDTH:0];
  always_ff @(posedge clk_12mhz) begin
    if (reset) begin
      almost_empty <= 1'b1;
      almost_full <= 1'b0;
    end else begin
      almost_empty <= occ_nxt <= AE;
      almost_full <= occ_nxt >= AF;
    end
  end
`else
  logic unused_levels;
  assign unused_levels = ^{AE_LEVEL, AF_LEVEL};
  assign almost_empty = 1'b0;
  assign almost_full = 1'b0;
`endif
endmodule

// File: tb/tb_data_fifo.sv
// tb_data_fifo: directed table-driven and sequence checks for data_fifo.
module tb_data_fifo;
  logic clk_12mhz = 1'b0;
  logic reset, rp_reset, wr_en, rd_en;
  logic [23:0] data, q;
  logic empty, full, almost_empty, almost_full;
  int checks = 0, errors = 0;
  typedef struct {
    logic wr;
    logic rd;
    logic [23:0] d;
    logic [23:0] q;
    int occ;
  } vec_t;
  vec_t v[10];
  logic [23:0] sb[$];
  int occ;
  data_fifo dut (
    .clk_12mhz(clk_12mhz), .reset(reset), .rp_reset(rp_reset), .data(data),
    .wr_en(wr_en), .rd_en(rd_en), .q(q), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full)
  );
  always #42 clk_12mhz = ~clk_12mhz;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic chk_flags(input string n, input int o);
    chk({n, " empty"}, {31'd0, empty}, {31'd0, o == 0});
    chk({n, " full"}, {31'd0, full}, {31'd0, o == 512});
`ifdef FIFO_ALMOST_FLAGS_EN
    chk({n, " almost_empty"}, {31'd0, almost_empty}, {31'd0, o <= 4});
    chk({n, " almost_full"}, {31'd0, almost_full}, {31'd0, o >= 508});
`else
    chk({n, " almost_empty"}, {31'd0, almost_empty}, 32'd0);
    chk({n, " almost_full"}, {31'd0, almost_full}, 32'd0);
`endif
  endtask
  task automatic step(input logic r, input logic rp, input logic w, input logic rd, input logic [23:0] d);
    reset = r;
    rp_reset = rp;
    wr_en = w;
    rd_en = rd;
    data = d;
    @(posedge clk_12mhz);
    #1;
  endtask
  initial begin
    step(1, 0, 0, 0, 0);
    #400;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("reset q", {8'd0, q}, 32'd0);
    chk_flags("reset", 0);
    v[0] = '{1, 0, 24'h000001, 24'h000000, 1};
    v[1] = '{1, 0, 24'h000002, 24'h000000, 2};
    v[2] = '{1, 0, 24'h000003, 24'h000000, 3};
    v[3] = '{0, 1, 24'h000000, 24'h000001, 2};
    v[4] = '{0, 1, 24'h000000, 24'h000002, 1};
    v[5] = '{0, 1, 24'h000000, 24'h000003, 0};
    v[6] = '{0, 1, 24'h000000, 24'h000003, 0};
    v[7] = '{1, 1, 24'h000004, 24'h000003, 1};
    v[8] = '{1, 1, 24'h000005, 24'h000004, 1};
    v[9] = '{0, 1, 24'h000000, 24'h000005, 0};
    for (int i = 0; i < 10; i++) begin
      step(0, 0, v[i].wr, v[i].rd, v[i].d);
      chk($sformatf("vec%0d q", i), {8'd0, q}, {8'd0, v[i].q});
      chk_flags($sformatf("vec%0d", i), v[i].occ);
    end
    step(1, 0, 0, 0, 0);
    occ = 0;
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 32; c++) begin
        logic w, rd, wa, ra;
        logic [23:0] d;
        w = c < 16;
        rd = c >= 5 && c <= 20;
        d = 24'(f * 32 + c + 1);
        wa = w && occ < 512;
        ra = rd && occ > 0;
        step(0, 0, w, rd, d);
        if (ra) chk($sformatf("frame%0d c%0d q", f, c), {8'd0, q}, {8'd0, sb.pop_front()});
        if (wa) sb.push_back(d);
        occ += int'(wa) - int'(ra);
        chk($sformatf("frame%0d c%0d empty", f, c), {31'd0, empty}, {31'd0, c >= 20});
        chk($sformatf("frame%0d c%0d full", f, c), {31'd0, full}, 32'd0);
      end
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 512; i++) begin
      step(0, 0, 1, 0, 24'(i + 1));
      if (i == 3 || i == 4 || i == 506 || i == 507 || i == 510 || i == 511)
        chk_flags($sformatf("fill%0d", i + 1), i + 1);
    end
    step(0, 0, 1, 0, 24'hABCDEF);
    chk_flags("overfill", 512);
    for (int i = 0; i < 512; i++) begin
      step(0, 0, 0, 1, 0);
      chk($sformatf("drain%0d q", i), {8'd0, q}, 32'(i + 1));
      if (i == 0 || i == 511) chk_flags($sformatf("drain%0d", i), 511 - i);
    end
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 24'(100 + i));
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1, 0);
      chk($sformatf("rw read%0d", i), {8'd0, q}, 32'(100 + i));
    end
    chk_flags("rw drained", 0);
    step(0, 1, 0, 1, 0);
    chk("rewind q hold", {8'd0, q}, 32'd109);
    chk_flags("rewind", 10);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1, 0);
      chk($sformatf("replay%0d", i), {8'd0, q}, 32'(100 + i));
    end
    chk_flags("replay done", 0);
    step(0, 1, 1, 0, 24'h000321);
    chk_flags("rewind+write", 11);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 24'(200 + i));
    step(0, 0, 0, 1, 0);
    chk("pre-reset q", {8'd0, q}, 32'd200);
    step(1, 0, 1, 1, 24'h000777);
    chk("midreset q", {8'd0, q}, 32'd0);
    chk_flags("midreset", 0);
    step(0, 0, 0, 1, 0);
    chk("post-reset read q", {8'd0, q}, 32'd0);
    chk_flags("post-reset read", 0);
    step(0, 0, 1, 0, 24'h000055);
    step(0, 0, 0, 1, 0);
    chk("post-reset first word", {8'd0, q}, 32'h55);
    chk_flags("post-reset end", 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
